// File: rtl/alu_pkg.sv
// Shared opcode definitions for the pipelined ALU.
// Opcode encodings and the opcode type used by the datapath.
package alu_pkg;

   localparam int OP_W = 3;

   typedef logic [OP_W-1:0] op_t;

   localparam op_t OP_XOR   = 3'd0;
   localparam op_t OP_AND   = 3'd1;
   localparam op_t OP_OR    = 3'd2;
   localparam op_t OP_ADD   = 3'd3;
   localparam op_t OP_NAND  = 3'd4;
   localparam op_t OP_NOR   = 3'd5;
   localparam op_t OP_MUX   = 3'd6;
   localparam op_t OP_PERES = 3'd7;

endpackage

// File: rtl/alu_op_unit.sv
// Combinational ALU datapath sitting between the s1 and s2 registers.
// Produces the selected function, the ADD carry and the zero flag.
module alu_op_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  op_t              op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero
);

   logic [WIDTH:0] sum;

   // Carry-in is only the LSB of C; the extra bit is the carry out.
   assign sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C[0]};

   always_comb begin
      result = '0;
      carry  = 1'b0;
      unique case (op)
         OP_XOR:   result = A ^ B;
         OP_AND:   result = A & B;
         OP_OR:    result = A | B;
         OP_ADD: begin
            result = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
         end
         OP_NAND:  result = ~(A & B);
         OP_NOR:   result = ~(A | B);
         OP_MUX:   result = (C & B) | (~C & A);
         OP_PERES: result = (A & B) ^ C;
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/pipelined_alu_hs.sv
// Two-stage valid/ready ALU pipeline with carry, zero and opcode tag.
// Optional handshake counter port op_count enabled by ALU_OPCOUNT_EN.
module pipelined_alu_hs #(
   parameter int WIDTH = 32,
   parameter int OP_W  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero,
   output logic [OP_W-1:0]  op_out
`ifdef ALU_OPCOUNT_EN
   ,
   output logic [31:0]      op_count
`endif
);

   import alu_pkg::*;

   logic             s1_valid;
   logic [OP_W-1:0]  s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [WIDTH-1:0] s1_c;
   logic             s2_valid;
   logic             s1_adv;
   logic             s2_adv;
   logic [WIDTH-1:0] alu_res;
   logic             alu_cy;
   logic             alu_zr;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv && !rst;
   assign out_valid = s2_valid;

   alu_op_unit #(
      .WIDTH(WIDTH)
   ) u_op (
      .op    (op_t'(s1_op)),
      .A     (s1_a),
      .B     (s1_b),
      .C     (s1_c),
      .result(alu_res),
      .carry (alu_cy),
      .zero  (alu_zr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_c     <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op <= op;
            s1_a  <= A;
            s1_b  <= B;
            s1_c  <= C;
         end
      end
   end

   // Output registers only move when s2 advances, so they hold under stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         zero      <= 1'b0;
         op_out    <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            result    <= alu_res;
            carry_out <= alu_cy;
            zero      <= alu_zr;
            op_out    <= s1_op;
         end
      end
   end

`ifdef ALU_OPCOUNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         op_count <= '0;
      else if (s2_valid && out_ready)
         op_count <= op_count + 32'd1;
   end
`endif

endmodule
